// File: rtl/handshake_syn_q.sv
// Four-phase req/ack clock-domain crossing with a source-side FIFO, a stable hold
// register for the crossing word and a registered, backpressured destination port.
module handshake_syn_q #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     sclk,
  input  logic                     dclk,
  input  logic                     rst_n,
  input  logic                     s_valid_i,
  input  logic [WIDTH-1:0]         s_data_i,
  output logic                     s_ready_o,
  output logic [$clog2(DEPTH):0]   s_count_o,
  output logic                     s_idle_o,
  output logic                     d_valid_o,
  output logic [WIDTH-1:0]         d_data_o,
  input  logic                     d_busy_i
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;
  localparam logic [0:0] D_IDLE = 1'b0;
  localparam logic [0:0] D_ACK  = 1'b1;

  // Source domain state
  logic [WIDTH-1:0]       mem_q [DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [WIDTH-1:0]       hold_q, hold_d;
  logic                   sreq_q, sreq_d;
  logic [1:0]             s_state_q, s_state_d;
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic                   sack, push, pop, fifo_empty;

  // Destination domain state
  logic [SYNC_STAGES-1:0] req_sync_q;
  logic                   dreq;
  logic [0:0]             d_state_q, d_state_d;
  logic                   dack_q, dack_d;
  logic                   d_valid_q, d_valid_d;
  logic [WIDTH-1:0]       d_data_q, d_data_d;

  assign sack       = ack_sync_q[SYNC_STAGES-1];
  assign dreq       = req_sync_q[SYNC_STAGES-1];
  assign fifo_empty = (count_q == '0);
  assign s_ready_o  = (count_q != CW'(DEPTH));
  assign s_count_o  = count_q;
  assign s_idle_o   = fifo_empty && (s_state_q == S_IDLE) && !sack;
  assign d_valid_o  = d_valid_q;
  assign d_data_o   = d_data_q;

  always_comb begin
    push      = s_valid_i && s_ready_o;
    pop       = 1'b0;
    sreq_d    = sreq_q;
    s_state_d = s_state_q;
    case (s_state_q)
      S_IDLE, S_DROP: begin
        // A new word may only launch once the previous ack has fully dropped.
        if (!sack && !fifo_empty) begin
          pop       = 1'b1;
          sreq_d    = 1'b1;
          s_state_d = S_REQ;
        end else if (!sack) begin
          s_state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (sack) begin
          sreq_d    = 1'b0;
          s_state_d = S_DROP;
        end
      end
      default: s_state_d = S_IDLE;
    endcase
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    hold_d   = pop ? mem_q[rd_ptr_q] : hold_q;
  end

  always_ff @(posedge sclk) begin
    if (push) mem_q[wr_ptr_q] <= s_data_i;
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      hold_q     <= '0;
      sreq_q     <= 1'b0;
      s_state_q  <= S_IDLE;
      ack_sync_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      hold_q     <= hold_d;
      sreq_q     <= sreq_d;
      s_state_q  <= s_state_d;
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], dack_q};
    end
  end

  always_comb begin
    d_state_d = d_state_q;
    dack_d    = dack_q;
    d_data_d  = d_data_q;
    d_valid_d = d_valid_q && d_busy_i;
    case (d_state_q)
      D_IDLE: begin
        // Holding off the ack while a word is unconsumed is what stalls the source.
        if (dreq && !d_valid_q) begin
          d_data_d  = hold_q;
          d_valid_d = 1'b1;
          dack_d    = 1'b1;
          d_state_d = D_ACK;
        end
      end
      D_ACK: begin
        if (!dreq) begin
          dack_d    = 1'b0;
          d_state_d = D_IDLE;
        end
      end
      default: d_state_d = D_IDLE;
    endcase
  end

  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n) begin
      req_sync_q <= '0;
      d_state_q  <= D_IDLE;
      dack_q     <= 1'b0;
      d_valid_q  <= 1'b0;
      d_data_q   <= '0;
    end else begin
      req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], sreq_q};
      d_state_q  <= d_state_d;
      dack_q     <= dack_d;
      d_valid_q  <= d_valid_d;
      d_data_q   <= d_data_d;
    end
  end

endmodule

// File: tb/tb_handshake_syn_q.sv
// Directed bench for handshake_syn_q: edge-exact latency, fill/backpressure,
// push/pop overlap with pointer wrap, clock ratios and reset mid-transfer.
module tb_handshake_syn_q;
  logic        sclk = 1'b0;
  logic        dclk = 1'b0;
  logic        rst_n = 1'b1;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_ready;
  logic [2:0]  s_count;
  logic        s_idle;
  logic        d_valid;
  logic [31:0] d_data;
  logic        d_busy = 1'b0;

  int s_half = 5;
  int d_half = 5;
  int checks = 0;
  int failures = 0;
  int rx_cnt = 0;
  logic [31:0] exp_q[$];
  bit busy_rand = 0;
  bit busy_force = 0;
  logic [31:0] hold_prev = '0;
  bit hold_prev_busy = 0;

  handshake_syn_q #(.WIDTH(32), .DEPTH(4), .SYNC_STAGES(2)) dut (
    .sclk(sclk), .dclk(dclk), .rst_n(rst_n),
    .s_valid_i(s_valid), .s_data_i(s_data), .s_ready_o(s_ready),
    .s_count_o(s_count), .s_idle_o(s_idle),
    .d_valid_o(d_valid), .d_data_o(d_data), .d_busy_i(d_busy)
  );

  always #(s_half) sclk = ~sclk;
  always #(d_half) dclk = ~dclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Consumer-side busy driver: forced level or random.
  initial begin
    forever begin
      @(negedge dclk);
      d_busy = busy_rand ? ($urandom_range(0, 2) == 0) : busy_force;
    end
  end

  always @(posedge sclk) begin
    if (rst_n && s_valid && s_ready) exp_q.push_back(s_data);
  end

  always @(posedge dclk) begin
    if (rst_n && d_valid && !d_busy) begin
      rx_cnt++;
      $display("rx %0d data=%h", rx_cnt, d_data);
      if (exp_q.size() == 0) check("sb_unexpected_word", 32'(exp_q.size()), 32'd1);
      else check("sb_word", d_data, exp_q.pop_front());
    end
  end

  // The crossing word must not move while the handshake is in flight.
  always @(negedge sclk) begin
    if (!rst_n) begin
      hold_prev_busy = 0;
    end else begin
      if (hold_prev_busy) check("hold_stable", dut.hold_q, hold_prev);
      hold_prev      = dut.hold_q;
      hold_prev_busy = dut.sreq_q || dut.sack;
    end
  end

  task automatic push_word(input logic [31:0] w, input int budget);
    bit acc;
    bit ok;
    ok = 0;
    s_valid = 1'b1;
    s_data = w;
    for (int n = 0; n < budget; n++) begin
      acc = s_ready;
      @(negedge sclk);
      if (acc) begin
        ok = 1;
        break;
      end
    end
    s_valid = 1'b0;
    check("push_accept", ok, 1);
  endtask

  task automatic wait_drain(input int budget);
    bit done;
    done = 0;
    for (int n = 0; n < budget; n++) begin
      @(negedge sclk);
      if (exp_q.size() == 0 && s_idle && !d_valid) begin
        done = 1;
        break;
      end
    end
    check("drain", done, 1);
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    busy_rand = 0;
    busy_force = 0;
    @(negedge sclk);
    rst_n = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge sclk);
    rst_n = 1'b1;
  endtask

  initial begin
    #(1_000_000);
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rx_base;
    bit found;
    logic [31:0] w4 [9];
    for (int i = 0; i < 9; i++) w4[i] = 32'h4000_0000 + 32'(i);

    // Single word, edge-exact latency.
    #1 rst_n = 1'b0;
    repeat (2) @(negedge sclk);
    check("rst_s_ready", s_ready, 1);
    check("rst_s_idle", s_idle, 1);
    check("rst_d_valid", d_valid, 0);
    check("rst_s_count", s_count, 0);
    check("rst_d_data", d_data, 0);
    rst_n = 1'b1;
    @(negedge sclk);
    s_valid = 1'b1;
    s_data = 32'hA5A5_0001;
    @(negedge sclk);
    s_valid = 1'b0;
    check("t1_count_e0", s_count, 1);
    for (int k = 1; k <= 13; k++) begin
      @(negedge sclk);
      check("t1_d_valid", d_valid, (k == 4));
      if (k == 1) check("t1_sreq_e1", dut.sreq_q, 1);
      if (k == 4) check("t1_d_data", d_data, 32'hA5A5_0001);
      if (k >= 12) check("t1_s_idle", s_idle, (k == 13));
    end

    // Fill to full under backpressure, then hold it for 40 destination cycles.
    rx_base = rx_cnt;
    busy_force = 1;
    for (int i = 0; i < 6; i++) push_word(32'h10 + 32'(i), 40);
    repeat (20) @(negedge sclk);
    check("t2_count_full", s_count, 4);
    check("t2_ready_low", s_ready, 0);
    check("t2_hold_second", dut.hold_q, 32'h11);
    for (int n = 0; n < 40; n++) begin
      @(negedge dclk);
      check("t3_d_valid", d_valid, 1);
      check("t3_d_data", d_data, 32'h10);
      check("t3_dack_low", dut.dack_q, 0);
      check("t3_count", s_count, 4);
    end
    busy_force = 0;
    wait_drain(400);
    check("t2_rx_count", 32'(rx_cnt - rx_base), 6);

    // Push on the very edge the FSM pops, with two words queued; then wrap.
    do_reset();
    rx_base = rx_cnt;
    for (int i = 0; i < 3; i++) push_word(w4[i], 4);
    repeat (10) @(negedge sclk);
    check("t4_count_before", s_count, 2);
    push_word(w4[3], 4);
    check("t4_count_same", s_count, 2);
    check("t4_wr_ptr", dut.wr_ptr_q, 0);
    check("t4_rd_ptr", dut.rd_ptr_q, 2);
    for (int i = 4; i < 9; i++) push_word(w4[i], 40);
    wait_drain(400);
    check("t4_wr_wrap", dut.wr_ptr_q, 1);
    check("t4_rd_wrap", dut.rd_ptr_q, 1);
    check("t4_count_empty", s_count, 0);
    check("t4_rx_count", 32'(rx_cnt - rx_base), 9);

    // Clock ratios with random consumer stalls.
    for (int r = 0; r < 2; r++) begin
      s_half = (r == 0) ? 15 : 5;
      d_half = (r == 0) ? 5 : 15;
      rx_base = rx_cnt;
      busy_rand = 1;
      for (int i = 0; i < 64; i++) push_word($urandom, 500);
      busy_rand = 0;
      busy_force = 0;
      wait_drain(3000);
      check("t5_rx_count", 32'(rx_cnt - rx_base), 64);
    end
    s_half = 5;
    d_half = 5;

    // Reset while both req and ack are high and a word sits unconsumed.
    @(negedge sclk);
    busy_force = 1;
    push_word(32'hDEAD_0006, 4);
    found = 0;
    for (int n = 0; n < 50; n++) begin
      if (dut.sreq_q && dut.dack_q) begin
        found = 1;
        break;
      end
      @(negedge sclk);
    end
    check("t6_in_flight", found, 1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t6_s_ready", s_ready, 1);
    check("t6_s_idle", s_idle, 1);
    check("t6_d_valid", d_valid, 0);
    check("t6_d_data", d_data, 0);
    check("t6_s_count", s_count, 0);
    busy_force = 0;
    repeat (3) @(negedge sclk);
    rst_n = 1'b1;
    @(negedge sclk);
    rx_base = rx_cnt;
    push_word(32'h0000_BEEF, 4);
    wait_drain(200);
    check("t6_rx_count", 32'(rx_cnt - rx_base), 1);
    check("t6_beef", d_data, 32'h0000_BEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
